// File: rtl/alu_mc_legv8.sv
// alu_mc_legv8: multi-cycle LEGv8 ALU with valid/ready on both sides.
//   Single-cycle ops (AND, OR, ADD, XOR, LSL, LSR) finish in one cycle.
//   Unsigned MUL (shift-add) and UDIV (restoring) take WIDTH+1 cycles.
//   F and status are registered and held until the consumer takes them.
// Ports:
//   clock, reset_n          : clock, synchronous active-low reset
//   in_valid / in_ready     : operation handshake (A, B, FS, C0)
//   out_valid / out_ready   : result handshake (F, status = {V, C, N, Z})
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no result pending, ready for a new operation
// S_BUSY | MUL/UDIV iterating, one step per cycle, counter counts down
// S_DONE | F/status valid, held until out_ready
module alu_mc_legv8 #(
  parameter int WIDTH = 64,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FS,
  input  logic             C0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       status
);

  localparam int CW = SW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [3:0]       status_q, status_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;

  assign in_ready  = ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready)) & reset_n;
  assign accept    = in_valid & in_ready;
  assign F         = f_q;
  assign status    = status_q;
  assign out_valid = out_valid_q;

  // Single-cycle datapath
  logic [WIDTH-1:0] a_p, b_p, quick_f;
  logic [WIDTH:0]   sum;
  logic             quick_c, quick_v;

  always_comb begin
    a_p     = FS[0] ? ~A : A;
    b_p     = FS[1] ? ~B : B;
    sum     = {1'b0, a_p} + {1'b0, b_p} + {{WIDTH{1'b0}}, C0};
    quick_f = '0;
    quick_c = 1'b0;
    quick_v = 1'b0;
    case (FS[4:2])
      3'b000: quick_f = a_p & b_p;
      3'b001: quick_f = a_p | b_p;
      3'b010: begin
        quick_f = sum[WIDTH-1:0];
        quick_c = sum[WIDTH];
        quick_v = ~(a_p[WIDTH-1] ^ b_p[WIDTH-1]) & (sum[WIDTH-1] ^ a_p[WIDTH-1]);
      end
      3'b011: quick_f = a_p ^ b_p;
      3'b100: quick_f = A << B[SW-1:0];
      3'b101: quick_f = A >> B[SW-1:0];
      default: quick_f = '0;
    endcase
  end

  // One iteration step. MUL: acc += a when b[0], a <<= 1, b >>= 1.
  // UDIV: acc is the partial remainder, a shifts the dividend out at the top
  // and the quotient bits in at the bottom, so a ends up holding the quotient.
  logic [WIDTH-1:0] step_a, step_b, step_acc, step_res;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;

  always_comb begin
    rem_sh = {acc_q, a_q[WIDTH-1]};
    div_ge = rem_sh >= {1'b0, b_q};
    if (is_div_q) begin
      // When div_ge the true difference is below B, so the low WIDTH bits suffice.
      step_acc = div_ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
      step_a   = {a_q[WIDTH-2:0], div_ge};
      step_b   = b_q;
      step_res = step_a;
    end else begin
      step_acc = acc_q + (b_q[0] ? a_q : '0);
      step_a   = a_q << 1;
      step_b   = b_q >> 1;
      step_res = step_acc;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    f_d         = f_q;
    status_d    = status_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      if (FS[4:3] == 2'b11) begin
        if (FS[2] && (B == '0)) begin
          f_d         = '0;
          status_d    = 4'b0001;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          a_d         = A;
          b_d         = B;
          acc_d       = '0;
          cnt_d       = CW'(WIDTH);
          is_div_d    = FS[2];
          out_valid_d = 1'b0;
          state_d     = S_BUSY;
        end
      end else begin
        f_d         = quick_f;
        status_d    = {quick_v, quick_c, quick_f[WIDTH-1], ~|quick_f};
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
    end else begin
      case (state_q)
        S_BUSY: begin
          a_d   = step_a;
          b_d   = step_b;
          acc_d = step_acc;
          cnt_d = cnt_q - CW'(1);
          // Last step registers its own result, giving WIDTH+1 cycles total.
          if (cnt_q == CW'(1)) begin
            f_d         = step_res;
            status_d    = {2'b00, step_res[WIDTH-1], ~|step_res};
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      f_q         <= '0;
      status_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      f_q         <= f_d;
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_mc_legv8.sv
module tb_alu_mc_legv8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;

  logic        iv64, ir64, ov64, ordy64, c0_64;
  logic [63:0] a64, b64, f64;
  logic [4:0]  fs64;
  logic [3:0]  st64;

  logic        iv32, ir32, ov32, ordy32, c0_32;
  logic [31:0] a32, b32, f32;
  logic [4:0]  fs32;
  logic [3:0]  st32;

  alu_mc_legv8 #(.WIDTH(64)) dut64 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(iv64), .in_ready(ir64),
    .A(a64), .B(b64), .FS(fs64), .C0(c0_64),
    .out_valid(ov64), .out_ready(ordy64),
    .F(f64), .status(st64)
  );

  alu_mc_legv8 #(.WIDTH(32)) dut32 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(iv32), .in_ready(ir32),
    .A(a32), .B(b32), .FS(fs32), .C0(c0_32),
    .out_valid(ov32), .out_ready(ordy32),
    .F(f32), .status(st32)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    bit          w32;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  fs;
    logic        c0;
    logic [63:0] ef;
    logic [3:0]  est;
    int          elat;
  } vec_t;

  vec_t vecs[$];

  // Presents one operation, counts posedges from the accepting edge (inclusive)
  // until out_valid is seen, then leaves the result held (out_ready=0).
  task automatic run_op(input bit w32, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] fs, input logic c0,
                        output logic [63:0] f, output logic [3:0] st,
                        output int lat, output bit ready_in_busy, output logic rdy_at_accept);
    @(negedge clock);
    if (w32) begin
      a32 = a[31:0]; b32 = b[31:0]; fs32 = fs; c0_32 = c0; iv32 = 1'b1; ordy32 = 1'b1;
    end else begin
      a64 = a; b64 = b; fs64 = fs; c0_64 = c0; iv64 = 1'b1; ordy64 = 1'b1;
    end
    #1;
    rdy_at_accept = w32 ? ir32 : ir64;
    lat = 0;
    ready_in_busy = 1'b0;
    while (lat < 300) begin
      @(posedge clock);
      lat++;
      #1;
      if (lat == 1) begin
        iv32 = 1'b0; ordy32 = 1'b0; iv64 = 1'b0; ordy64 = 1'b0;
      end
      if (w32 ? ov32 : ov64) break;
      if (w32 ? ir32 : ir64) ready_in_busy = 1'b1;
    end
    f  = w32 ? {32'h0, f32} : f64;
    st = w32 ? st32 : st64;
  endtask

  logic [63:0] f_got;
  logic [3:0]  st_got;
  int          lat_got;
  bit          rib;
  logic        rdy_acc;
  bit          stable;

  initial begin
    vecs.push_back('{"add_ovf",      0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 5'b01000, 1'b0, 64'h8000_0000_0000_0000, 4'b1010, 1});
    vecs.push_back('{"sub_equal",    0, 64'h5, 64'h5, 5'b01010, 1'b1, 64'h0, 4'b0101, 1});
    vecs.push_back('{"add_cin_wrap", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'b01000, 1'b1, 64'h0, 4'b0101, 1});
    vecs.push_back('{"add_neg_ovf",  0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'b01000, 1'b0, 64'h0, 4'b1101, 1});
    vecs.push_back('{"and",          0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'b00000, 1'b0, 64'hF000_F000_F000_F000, 4'b0010, 1});
    vecs.push_back('{"or_inv_a",     0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 5'b00101, 1'b0, 64'h1234, 4'b0000, 1});
    vecs.push_back('{"xor_zero",     0, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 5'b01100, 1'b0, 64'h0, 4'b0001, 1});
    vecs.push_back('{"lsl63",        0, 64'h1, 64'd63, 5'b10000, 1'b0, 64'h8000_0000_0000_0000, 4'b0010, 1});
    vecs.push_back('{"lsl_amt_mask", 0, 64'h3, 64'h104, 5'b10011, 1'b0, 64'h30, 4'b0000, 1});
    vecs.push_back('{"lsr63",        0, 64'h8000_0000_0000_0000, 64'd63, 5'b10100, 1'b0, 64'h1, 4'b0000, 1});
    vecs.push_back('{"mul_big",      0, 64'hFFFF_FFFF, 64'h1_0000_0001, 5'b11000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 65});
    vecs.push_back('{"mul_inv_ign",  0, 64'h3, 64'h5, 5'b11011, 1'b0, 64'd15, 4'b0000, 65});
    vecs.push_back('{"udiv_100_7",   0, 64'd100, 64'd7, 5'b11100, 1'b0, 64'd14, 4'b0000, 65});
    vecs.push_back('{"udiv_by0",     0, 64'd100, 64'd0, 5'b11100, 1'b0, 64'h0, 4'b0001, 1});
    vecs.push_back('{"udiv_by1",     0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b11100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 65});
    vecs.push_back('{"add_ovf32",    1, 64'h7FFF_FFFF, 64'h1, 5'b01000, 1'b0, 64'h8000_0000, 4'b1010, 1});
    vecs.push_back('{"sub_equal32",  1, 64'h5, 64'h5, 5'b01010, 1'b1, 64'h0, 4'b0101, 1});
    vecs.push_back('{"lsl31_32",     1, 64'h1, 64'd31, 5'b10000, 1'b0, 64'h8000_0000, 4'b0010, 1});
    vecs.push_back('{"lsl_mask32",   1, 64'h1, 64'd33, 5'b10000, 1'b0, 64'h2, 4'b0000, 1});
    vecs.push_back('{"lsr31_32",     1, 64'h8000_0000, 64'd31, 5'b10100, 1'b0, 64'h1, 4'b0000, 1});
    vecs.push_back('{"udiv32",       1, 64'd100, 64'd7, 5'b11100, 1'b0, 64'd14, 4'b0000, 33});

    reset_n = 1'b0;
    iv64 = 0; ordy64 = 0; a64 = '0; b64 = '0; fs64 = '0; c0_64 = 0;
    iv32 = 0; ordy32 = 0; a32 = '0; b32 = '0; fs32 = '0; c0_32 = 0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready64", {63'h0, ir64}, 64'h0);
    check("rst_in_ready32", {63'h0, ir32}, 64'h0);
    check("rst_out_valid",  {63'h0, ov64}, 64'h0);
    check("rst_F",          f64, 64'h0);
    check("rst_status",     {60'h0, st64}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("idle_in_ready64", {63'h0, ir64}, 64'h1);
    check("idle_in_ready32", {63'h0, ir32}, 64'h1);

    // Table-driven vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].w32, vecs[i].a, vecs[i].b, vecs[i].fs, vecs[i].c0, f_got, st_got, lat_got, rib, rdy_acc);
      check({vecs[i].name, "_ready"},   {63'h0, rdy_acc}, 64'h1);
      check({vecs[i].name, "_F"},       f_got, vecs[i].ef);
      check({vecs[i].name, "_status"},  {60'h0, st_got}, {60'h0, vecs[i].est});
      check({vecs[i].name, "_latency"}, 64'(lat_got), 64'(vecs[i].elat));
      if (vecs[i].elat > 1) check({vecs[i].name, "_busy_in_ready"}, {63'h0, rib}, 64'h0);
    end

    // Backpressure on an XOR result, then back-to-back AND
    run_op(1'b0, 64'hFF, 64'h0F, 5'b01100, 1'b0, f_got, st_got, lat_got, rib, rdy_acc);
    check("bp_xor_F", f_got, 64'hF0);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (f64 !== 64'hF0 || ov64 !== 1'b1 || st64 !== 4'b0000) stable = 1'b0;
    end
    check("bp_held_stable", {63'h0, stable}, 64'h1);
    @(negedge clock);
    ordy64 = 1'b1; iv64 = 1'b1; a64 = 64'hF0; b64 = 64'h3C; fs64 = 5'b00000; c0_64 = 1'b0;
    #1;
    check("b2b_in_ready", {63'h0, ir64}, 64'h1);
    @(posedge clock);
    #1;
    iv64 = 1'b0; ordy64 = 1'b0;
    check("b2b_out_valid", {63'h0, ov64}, 64'h1);
    check("b2b_F", f64, 64'h30);
    @(negedge clock);
    ordy64 = 1'b1;
    @(posedge clock);
    #1;
    ordy64 = 1'b0;
    check("consume_to_idle", {63'h0, ov64}, 64'h0);

    // Reset in the middle of a MUL
    @(negedge clock);
    a64 = 64'hFFFF_FFFF; b64 = 64'h1_0000_0001; fs64 = 5'b11000; iv64 = 1'b1; ordy64 = 1'b1;
    @(posedge clock);
    #1;
    iv64 = 1'b0; ordy64 = 1'b0;
    repeat (30) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_out_valid", {63'h0, ov64}, 64'h0);
    check("midrst_F",         f64, 64'h0);
    check("midrst_status",    {60'h0, st64}, 64'h0);
    check("midrst_in_ready",  {63'h0, ir64}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("postrst_in_ready", {63'h0, ir64}, 64'h1);
    run_op(1'b0, 64'h1, 64'd63, 5'b10000, 1'b0, f_got, st_got, lat_got, rib, rdy_acc);
    check("postrst_lsl_F",       f_got, 64'h8000_0000_0000_0000);
    check("postrst_lsl_latency", 64'(lat_got), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
